fifo_ctrl: RTL
==============

// Module: fifo_ctrl
// PURPOSE
//  Pointer/occupancy controller sequencing the FIFO memory array storage block.
//  Turns valid/ready push/pop handshakes into write/read enables and pointers.
//  Provides full/empty/threshold status and an occupancy count.
//  Sits between the producer/consumer interfaces and the memory array; array data paths bypass it.
// PARAMETERS
//  DATA_WIDTH      32            data width (passed through to the array; unused in the controller)
//  OSTD_NUM        8             FIFO depth in entries; >=2, need not be a power of 2
//  THRESHOLD_VALUE OSTD_NUM/2    almost_empty asserted when count < THRESHOLD_VALUE
//  PTR_SIZE        $clog2(OSTD_NUM)  pointer width; localparam CNT_SIZE = $clog2(OSTD_NUM+1)
// PORTS
//  clk_in        in   1         clock; all state on rising edge
//  areset        in   1         asynchronous reset, active-high
//  flush         in   1         synchronous flush; empties FIFO
//  wr_valid      in   1         producer has a push
//  wr_ready      out  1         push accepted this cycle when wr_valid&wr_ready
//  rd_valid      out  1         array data_out holds the head entry
//  rd_ready      in   1         consumer takes head this cycle when rd_valid&rd_ready
//  fifo_wenable  out  1         write strobe to array = wr_valid & wr_ready
//  fifo_renable  out  1         read enable to array = rd_valid
//  write_ptr     out  PTR_SIZE  array write index
//  read_ptr      out  PTR_SIZE  array read index (head)
//  count         out  CNT_SIZE  occupancy 0..OSTD_NUM
//  full          out  1         count == OSTD_NUM
//  empty         out  1         count == 0
//  almost_empty  out  1         count < THRESHOLD_VALUE
//  err_clr       in   1         clears sticky error flags (FIFO_CTRL_ERR_EN only)
//  overflow_err  out  1         sticky: wr_valid seen while full
//  underflow_err out  1         sticky: rd_ready seen while empty
// BEHAVIOUR
//  - Reset (async, areset=1): both pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1
//    (THRESHOLD_VALUE > 0), wr_ready = 1, rd_valid = 0, enables = 0, err flags = 0.
//    Reset mid-transfer discards all contents; a push on the deasserting edge is not taken.
//  - State FSM (registered): EMPTY -> PARTIAL on push-only; PARTIAL -> FULL when a push-only
//    makes count = OSTD_NUM; PARTIAL -> EMPTY when a pop-only makes count = 0; FULL -> PARTIAL on pop.
//    OSTD_NUM = 1 is not supported.
//  - wr_ready = ~full; rd_valid = ~empty. Both are purely combinational from registered state,
//    with no combinational path from wr_valid/rd_ready.
//  - push = wr_valid & wr_ready: write_ptr advances next edge.
//    pop = rd_valid & rd_ready: read_ptr advances next edge.
//  - Pointer wrap: OSTD_NUM-1 -> 0 (modulo OSTD_NUM, not 2**PTR_SIZE).
//  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push & pop (both pointers move).
//  - Full FIFO: no push, even with a same-cycle pop (wr_ready=0). Empty FIFO: no pop; no write-through.
//  - Latency: a pushed entry is visible on rd_valid/data_out the cycle after its push.
//  - flush=1: next edge pointers = 0, count = 0, state EMPTY; same-cycle push/pop ignored.
//    flush has priority below areset, above all else.
//  - Status outputs are registered-derived; full/empty never both 1.
// CONFIGURATION
//  FIFO_CTRL_ERR_EN defined: overflow_err sets on wr_valid&full; underflow_err sets on rd_ready&empty.
//   Both are sticky until err_clr (clear wins over set in the same cycle); flush does not clear them.
//  FIFO_CTRL_ERR_EN undefined: overflow_err/underflow_err tied 0, err_clr ignored; no flops inferred.
// TESTING
//  1 Reset then 8 pushes (OSTD_NUM=8), no pops -> count 1..8; full=1 after 8th; wr_ready=0; write_ptr=0.
//  2 From full, 8 pops -> read_ptr 1..7,0; empty=1 after last; almost_empty rises when count goes 4->3.
//  3 Count=3, push&pop every cycle for 20 cycles -> count stays 3, pointers wrap 7->0, data order preserved.
//  4 Full, wr_valid=1 & rd_ready=1 -> only pop occurs, count 8->7; next cycle push accepted -> count 8.
//  5 Count=5, assert flush with wr_valid=1 -> next cycle count=0, pointers=0, empty=1, no write.
//  6 ERR_EN: push while full -> overflow_err=1 held; pop while empty -> underflow_err=1;
//    err_clr -> both 0 next cycle; areset mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller sequencing a FIFO memory array.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow error flags.
module fifo_ctrl #(
    parameter int  DATA_WIDTH      = 32,
    parameter int  OSTD_NUM        = 8,
    parameter int  THRESHOLD_VALUE = OSTD_NUM / 2,
    parameter int  PTR_SIZE        = $clog2(OSTD_NUM),
    localparam int CNT_SIZE        = $clog2(OSTD_NUM + 1)
) (
    input  logic                clk_in,
    input  logic                areset,
    input  logic                flush,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                fifo_wenable,
    output logic                fifo_renable,
    output logic [PTR_SIZE-1:0] write_ptr,
    output logic [PTR_SIZE-1:0] read_ptr,
    output logic [CNT_SIZE-1:0] count,
    output logic                full,
    output logic                empty,
    output logic                almost_empty,
    input  logic                err_clr,
    output logic                overflow_err,
    output logic                underflow_err
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t              state_r;
    logic [PTR_SIZE-1:0] wr_ptr_r;
    logic [PTR_SIZE-1:0] rd_ptr_r;
    logic [CNT_SIZE-1:0] count_r;
    logic                almost_empty_r;
    logic                push_s;
    logic                pop_s;
    logic [31:0]         unused_width_s;

    // Pointers wrap at the depth, which need not be a power of two.
    function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] p);
        return (p == PTR_SIZE'(OSTD_NUM - 1)) ? {PTR_SIZE{1'b0}} : p + PTR_SIZE'(1);
    endfunction

    function automatic logic below_thr(input logic [CNT_SIZE-1:0] c);
        return int'(c) < THRESHOLD_VALUE;
    endfunction

    assign unused_width_s = 32'(DATA_WIDTH);

    assign full         = (state_r == ST_FULL);
    assign empty        = (state_r == ST_EMPTY);
    assign wr_ready     = ~full;
    assign rd_valid     = ~empty;
    assign push_s       = wr_valid & wr_ready & ~flush;
    assign pop_s        = rd_valid & rd_ready & ~flush;
    assign fifo_wenable = push_s;
    assign fifo_renable = rd_valid;
    assign write_ptr    = wr_ptr_r;
    assign read_ptr     = rd_ptr_r;
    assign count        = count_r;
    assign almost_empty = almost_empty_r;

    // Occupancy FSM, pointers, count and threshold flag.
    always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
            state_r        <= ST_EMPTY;
            wr_ptr_r       <= {PTR_SIZE{1'b0}};
            rd_ptr_r       <= {PTR_SIZE{1'b0}};
            count_r        <= {CNT_SIZE{1'b0}};
            almost_empty_r <= below_thr({CNT_SIZE{1'b0}});
        end else if (flush) begin
            state_r        <= ST_EMPTY;
            wr_ptr_r       <= {PTR_SIZE{1'b0}};
            rd_ptr_r       <= {PTR_SIZE{1'b0}};
            count_r        <= {CNT_SIZE{1'b0}};
            almost_empty_r <= below_thr({CNT_SIZE{1'b0}});
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10: begin
                    count_r        <= count_r + CNT_SIZE'(1);
                    almost_empty_r <= below_thr(count_r + CNT_SIZE'(1));
                    state_r        <= (count_r == CNT_SIZE'(OSTD_NUM - 1)) ? ST_FULL : ST_PARTIAL;
                end
                2'b01: begin
                    count_r        <= count_r - CNT_SIZE'(1);
                    almost_empty_r <= below_thr(count_r - CNT_SIZE'(1));
                    state_r        <= (count_r == CNT_SIZE'(1)) ? ST_EMPTY : ST_PARTIAL;
                end
                default: begin
                    count_r        <= count_r;
                    almost_empty_r <= almost_empty_r;
                    state_r        <= state_r;
                end
            endcase
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error capture; clear beats a same-cycle set and flush leaves them alone.
    always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (err_clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_valid & full) begin
                overflow_r <= 1'b1;
            end
            if (rd_ready & empty) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow_err  = overflow_r;
    assign underflow_err = underflow_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr;
    assign overflow_err     = 1'b0;
    assign underflow_err    = 1'b0;
`endif

endmodule
